// File: rtl/spike_event_arbiter.sv
// Round-robin spike event collector with a small FIFO and an idle-gated
// dispatch FSM feeding the neuron-core controller one event at a time.
module spike_event_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int HOLDOFF    = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]     src_addr,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic                          core_idle,
  output logic [ADDR_W-1:0]             event_addr,
  output logic                          event_received,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(NUM_SRC);
  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SW-1:0]       r_rr_ptr;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW:0]         r_level;
  logic [3:0]          r_hold_cnt;
  logic [ADDR_W-1:0]   r_event_addr;
  logic [ADDR_W-1:0]   r_mem [FIFO_DEPTH];

  logic [ADDR_W-1:0]   w_addr [NUM_SRC];
  logic [NUM_SRC-1:0]  w_gnt;
  logic [SW-1:0]       w_gidx;
  logic                w_found;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_load_hold;
  logic [SW-1:0]       w_rr_nxt;

  assign w_full = (r_level == (PW+1)'(FIFO_DEPTH));

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_addr[i] = src_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Scan upward from rr_ptr with wrap; first requester wins.
  always_comb begin
    logic [SW:0] v_sum;
    logic [SW-1:0] v_idx;
    w_gnt   = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    v_sum   = '0;
    v_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (SW+1)'(k);
      if (v_sum >= (SW+1)'(NUM_SRC)) begin
        v_sum = v_sum - (SW+1)'(NUM_SRC);
      end
      v_idx = v_sum[SW-1:0];
      if (!w_found && !w_full && src_valid[v_idx]) begin
        w_found      = 1'b1;
        w_gidx       = v_idx;
        w_gnt[v_idx] = 1'b1;
      end
    end
  end

  assign src_ready = w_gnt;
  assign w_push    = w_found;
  assign w_rr_nxt  = (w_gidx == SW'(NUM_SRC - 1)) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_addr[w_gidx];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_rr_ptr <= w_rr_nxt;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = w_pop ? S_ISSUE : S_IDLE;
      S_ISSUE: w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = (r_hold_cnt == '0) ? S_IDLE : S_HOLD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop          = 1'b0;
    w_load_hold    = 1'b0;
    event_received = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = (r_level != '0) && core_idle;
      S_ISSUE: begin
        event_received = 1'b1;
        w_load_hold    = 1'b1;
      end
      default: ;
    endcase
  end

  // Hold-off gives the core time to drop core_idle before re-sampling.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_cnt   <= '0;
      r_event_addr <= '0;
    end else begin
      if (w_load_hold) begin
        r_hold_cnt <= HOLD_INIT;
      end else if (r_state == S_HOLD && r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
      if (w_pop) begin
        r_event_addr <= r_mem[r_rd_ptr];
      end
    end
  end

  assign event_addr = r_event_addr;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Scoreboard bench for spike_event_arbiter: directed stimulus pushes
// expected dispatch addresses; a negedge monitor checks each pulse.
module tb_spike_event_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  src_valid = '0;
  logic [15:0] src_addr = '0;
  logic [3:0]  src_ready;
  logic        core_idle = 1'b0;
  logic [3:0]  event_addr;
  logic        event_received;
  logic [3:0]  fifo_level;

  spike_event_arbiter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .src_valid      (src_valid),
    .src_addr       (src_addr),
    .src_ready      (src_ready),
    .core_idle      (core_idle),
    .event_addr     (event_addr),
    .event_received (event_received),
    .fifo_level     (fifo_level)
  );

  always #5 clock = ~clock;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [3:0] exp_q [$];
  logic [3:0] mon_e;
  int         pulses = 0;
  int         cyc = 0;
  int         prev_pulse = -1;
  int         last_gap = 0;
  int         base;

  function automatic void chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endfunction

  always @(negedge clock) begin
    cyc++;
    if (reset_n && event_received) begin
      pulses++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got addr %0d required none", event_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dispatch_addr", int'(event_addr), int'(mon_e));
      end
      if (prev_pulse >= 0) begin
        last_gap = cyc - prev_pulse;
        n_chk++;
        if (last_gap < 4) begin
          n_fail++;
          $display("FAIL pulse_spacing: got %0d required >=4", last_gap);
        end
      end
      prev_pulse = cyc;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    src_valid = '0;
    src_addr  = '0;
    core_idle = 1'b0;
    exp_q.delete();
    prev_pulse = -1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic send(input int s, input logic [3:0] a);
    int n;
    n = 0;
    src_valid[s]       = 1'b1;
    src_addr[s*4 +: 4] = a;
    @(negedge clock);
    while (!src_ready[s] && n < 200) begin
      @(negedge clock);
      n++;
    end
    n_chk++;
    if (!src_ready[s]) begin
      n_fail++;
      $display("FAIL grant_timeout: got no grant for src %0d required grant", s);
    end else begin
      exp_q.push_back(a);
    end
    tick();
    src_valid[s] = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
    end
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    do_reset();
    @(negedge clock);
    chk("rst_src_ready", int'(src_ready), 0);
    chk("rst_event_received", int'(event_received), 0);
    chk("rst_event_addr", int'(event_addr), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);

    // single event latency
    tick();
    core_idle      = 1'b1;
    src_valid      = 4'b0100;
    src_addr[8+:4] = 4'hA;
    @(negedge clock);
    chk("single_grant", int'(src_ready), 4);
    exp_q.push_back(4'hA);
    tick();
    src_valid = '0;
    @(negedge clock);
    chk("single_level_t1", int'(fifo_level), 1);
    chk("single_no_early_pulse", int'(event_received), 0);
    @(negedge clock);
    chk("single_pulse_t2", int'(event_received), 1);
    chk("single_addr_t2", int'(event_addr), 10);
    @(negedge clock);
    chk("single_pulse_width", int'(event_received), 0);
    chk("single_level_end", int'(fifo_level), 0);
    wait_drain(50);

    // round robin fill
    do_reset();
    src_addr  = {4'd4, 4'd3, 4'd2, 4'd1};
    src_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("rr_grant", int'(src_ready), 1 << (k % 4));
      exp_q.push_back(4'((k % 4) + 1));
    end
    @(negedge clock);
    chk("full_level", int'(fifo_level), 8);
    chk("full_no_grant", int'(src_ready), 0);
    @(negedge clock);
    chk("full_no_grant2", int'(src_ready), 0);

    // pop from full: no grant in pop cycle, grant the cycle after
    tick();
    core_idle = 1'b1;
    @(negedge clock);
    chk("pop_cycle_no_grant", int'(src_ready), 0);
    chk("pop_cycle_level", int'(fifo_level), 8);
    @(negedge clock);
    chk("after_pop_level", int'(fifo_level), 7);
    chk("after_pop_grant", int'(src_ready), 1);
    exp_q.push_back(4'd1);
    tick();
    src_valid = '0;
    @(negedge clock);
    chk("refill_level", int'(fifo_level), 8);
    wait_drain(200);
    chk("drained_level", int'(fifo_level), 0);

    // core busy then release
    core_idle = 1'b0;
    base = pulses;
    send(1, 4'd5);
    send(3, 4'd6);
    send(0, 4'd7);
    @(negedge clock);
    chk("busy_level", int'(fifo_level), 3);
    repeat (8) @(negedge clock);
    chk("busy_no_pulse", pulses - base, 0);
    tick();
    core_idle = 1'b1;
    wait_drain(100);
    chk("busy_pulse_count", pulses - base, 3);
    chk("busy_spacing", last_gap, 4);

    // push and pop in the same cycle
    core_idle = 1'b0;
    send(2, 4'd8);
    tick();
    core_idle       = 1'b1;
    src_valid[1]    = 1'b1;
    src_addr[4 +: 4] = 4'd9;
    @(negedge clock);
    chk("coinc_grant", int'(src_ready), 2);
    chk("coinc_level_before", int'(fifo_level), 1);
    exp_q.push_back(4'd9);
    tick();
    src_valid = '0;
    @(negedge clock);
    chk("coinc_level_after", int'(fifo_level), 1);
    wait_drain(100);

    // pointer wrap with 20 events
    base = pulses;
    for (int k = 0; k < 20; k++) begin
      send(k % 4, 4'((k * 5 + 3) % 16));
    end
    wait_drain(300);
    chk("wrap_pulse_count", pulses - base, 20);
    chk("wrap_level", int'(fifo_level), 0);

    // async reset during HOLD
    core_idle = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send(k % 4, 4'(k + 1));
    end
    @(negedge clock);
    chk("pre_rst_level", int'(fifo_level), 6);
    tick();
    core_idle = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #3;
    chk("hold_level", int'(fifo_level), 5);
    reset_n = 1'b0;
    #1;
    chk("arst_event_received", int'(event_received), 0);
    chk("arst_event_addr", int'(event_addr), 0);
    chk("arst_fifo_level", int'(fifo_level), 0);
    chk("arst_src_ready", int'(src_ready), 0);
    exp_q.delete();
    prev_pulse = -1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    base = pulses;
    repeat (10) @(negedge clock);
    chk("post_rst_no_pulse", pulses - base, 0);
    chk("post_rst_level", int'(fifo_level), 0);
    tick();
    send(3, 4'hC);
    wait_drain(50);
    chk("post_rst_new_event", pulses - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
